// File: rtl/val2_pkg.sv
// Shared types and constants for the val2 shifter-operand pipeline.
package val2_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    MODE_MEM,
    MODE_IMM,
    MODE_ISH,
    MODE_RSH
  } mode_t;

  // Decoded operation handed from the decode step to the barrel step.
  // amt is the effective shift amount: 0 = pass Rm with c_in, 32 = full-width
  // shift, 33 = "beyond 32" (only meaningful for LSL/LSR).
  typedef struct packed {
    logic [DATA_W-1:0] rm;
    logic [5:0]        amt;
    logic [1:0]        typ;
    logic              rrx;
    logic              c_in;
  } dec_t;

  // Register shift amounts above 32 all behave alike, so fold them onto 33.
  function automatic logic [5:0] clamp_amt(input logic [7:0] s);
    return (s > 8'd32) ? 6'd33 : s[5:0];
  endfunction

endpackage

// File: rtl/val2_barrel.sv
// Combinational barrel shifter with shifter carry-out.
module val2_barrel
  import val2_pkg::*;
(
  input  logic [DATA_W-1:0] rm,
  input  logic [5:0]        amt,
  input  logic [1:0]        typ,
  input  logic              c_in,
  input  logic              rrx,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [4:0] sh;
  logic [4:0] idx_lo;
  logic [4:0] idx_hi;

  // idx_lo = amt-1 and idx_hi = 32-amt, both valid whenever 1 <= amt <= 31.
  assign sh     = amt[4:0];
  assign idx_lo = sh - 5'd1;
  assign idx_hi = 5'd0 - sh;

  // Shift/rotate and select the last bit shifted out.
  always_comb begin
    result = rm;
    carry  = c_in;
    if (rrx) begin
      result = {c_in, rm[DATA_W-1:1]};
      carry  = rm[0];
    end else if (amt != 6'd0) begin
      case (typ)
        SH_LSL: begin
          if (!amt[5]) begin
            result = rm << sh;
            carry  = rm[idx_hi];
          end else begin
            result = '0;
            carry  = (amt == 6'd32) ? rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (!amt[5]) begin
            result = rm >> sh;
            carry  = rm[idx_lo];
          end else begin
            result = '0;
            carry  = (amt == 6'd32) ? rm[DATA_W-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (!amt[5]) begin
            result = $unsigned($signed(rm) >>> sh);
            carry  = rm[idx_lo];
          end else begin
            result = {DATA_W{rm[DATA_W-1]}};
            carry  = rm[DATA_W-1];
          end
        end
        default: begin
          // ROR by a multiple of 32 leaves Rm unchanged but still reports bit 31.
          if (sh == 5'd0) begin
            result = rm;
            carry  = rm[DATA_W-1];
          end else begin
            result = (rm >> sh) | (rm << (6'd32 - {1'b0, sh}));
            carry  = rm[idx_lo];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_pipe.sv
// Pipelined val2 / shifter carry generator with valid-ready handshake and flush.
module val2_shift_pipe
  import val2_pkg::*;
#(
  parameter int PIPE_DEPTH   = 2,
  parameter int MEM_SEXT     = 1,
  parameter int REG_SHIFT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm,
  input  logic              mem_off,
  input  logic [11:0]       shifter_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              c_out
);

  mode_t             mode;
  dec_t              dec;
  dec_t              bar_in;
  logic [DATA_W-1:0] bar_res;
  logic              bar_c;
  logic              out_adv;
  logic [4:0]        n_imm;
  logic [1:0]        typ_f;

  assign n_imm   = shifter_operand[11:7];
  assign typ_f   = shifter_operand[6:5];
  assign out_adv = !out_valid || out_ready;

  // Mode selection in priority order.
  always_comb begin
    if (mem_off)                  mode = MODE_MEM;
    else if (imm)                 mode = MODE_IMM;
    else if (!shifter_operand[4]) mode = MODE_ISH;
    else                          mode = MODE_RSH;
  end

  // Map every mode onto one barrel operation with an effective 6-bit amount.
  always_comb begin
    dec.rm   = val_rm;
    dec.amt  = 6'd0;
    dec.typ  = typ_f;
    dec.rrx  = 1'b0;
    dec.c_in = c_in;
    case (mode)
      MODE_MEM: begin
        dec.rm  = (MEM_SEXT != 0) ? {{(DATA_W-12){shifter_operand[11]}}, shifter_operand}
                                  : {{(DATA_W-12){1'b0}}, shifter_operand};
        dec.typ = SH_LSL;
      end
      MODE_IMM: begin
        // Rotate amount 2*rot is at most 30, so the barrel's ROR carry is result[31].
        dec.rm  = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
        dec.amt = {1'b0, shifter_operand[11:8], 1'b0};
        dec.typ = SH_ROR;
      end
      MODE_ISH: begin
        if (n_imm == 5'd0) begin
          case (typ_f)
            SH_LSL:  dec.amt = 6'd0;
            SH_ROR:  dec.rrx = 1'b1;
            default: dec.amt = 6'd32;
          endcase
        end else begin
          dec.amt = {1'b0, n_imm};
        end
      end
      default: begin
        if (REG_SHIFT_EN == 0) begin
          dec.rm = '0;
        end else if (typ_f == SH_ROR) begin
          if (val_rs == 8'd0)           dec.amt = 6'd0;
          else if (val_rs[4:0] == 5'd0) dec.amt = 6'd32;
          else                          dec.amt = {1'b0, val_rs[4:0]};
        end else begin
          dec.amt = clamp_amt(val_rs);
        end
      end
    endcase
  end

  generate
    if (PIPE_DEPTH == 1) begin : g_one
      assign in_ready = out_adv;
      assign bar_in   = dec;

      // Single stage: output valid tracks accepted inputs.
      always_ff @(posedge clk) begin
        if (rst || flush)  out_valid <= 1'b0;
        else if (out_adv)  out_valid <= in_valid;
      end

      // Single stage: capture shifted result on accept.
      always_ff @(posedge clk) begin
        if (rst) begin
          val2  <= '0;
          c_out <= 1'b0;
        end else if (out_adv && in_valid) begin
          val2  <= bar_res;
          c_out <= bar_c;
        end
      end
    end else begin : g_two
      logic s1_valid;
      logic s1_adv;
      dec_t s1_q;

      assign s1_adv   = !s1_valid || out_adv;
      assign in_ready = s1_adv;
      assign bar_in   = s1_q;

      // Stage 1 valid bit.
      always_ff @(posedge clk) begin
        if (rst || flush) s1_valid <= 1'b0;
        else if (s1_adv)  s1_valid <= in_valid;
      end

      // Stage 1 decoded operands.
      always_ff @(posedge clk) begin
        if (rst)                     s1_q <= '0;
        else if (s1_adv && in_valid) s1_q <= dec;
      end

      // Stage 2 valid bit.
      always_ff @(posedge clk) begin
        if (rst || flush) out_valid <= 1'b0;
        else if (out_adv) out_valid <= s1_valid;
      end

      // Stage 2 registered result.
      always_ff @(posedge clk) begin
        if (rst) begin
          val2  <= '0;
          c_out <= 1'b0;
        end else if (out_adv && s1_valid) begin
          val2  <= bar_res;
          c_out <= bar_c;
        end
      end
    end
  endgenerate

  val2_barrel u_barrel (
    .rm     (bar_in.rm),
    .amt    (bar_in.amt),
    .typ    (bar_in.typ),
    .c_in   (bar_in.c_in),
    .rrx    (bar_in.rrx),
    .result (bar_res),
    .carry  (bar_c)
  );

endmodule

// File: doc/val2_shift_pipe.md
Name: val2_shift_pipe

Overview:
Pipelined second-operand generator for the EXE stage. It computes val2 and the shifter carry-out from an instruction's shifter_operand field. It covers every mode: rotated immediate, immediate shift, register-specified shift (Rs), RRX, and load/store immediate offset. Compared with the combinational generator, it adds register shifts, a carry-out, a valid/ready handshake, a flush input and a configurable pipeline depth.

Parameters:
PIPE_DEPTH, 2, number of register stages (1 or 2); latency in cycles equals PIPE_DEPTH.
MEM_SEXT, 1, 1 = sign-extend the 12-bit memory offset to 32 bits; 0 = zero-extend.
REG_SHIFT_EN, 1, 0 = register-shift encodings produce val2=0 and c_out=c_in (legacy mode).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  kill all in-flight entries (pipeline flush).
in_valid  in  1  the input bundle is valid.
in_ready  out  1  the block accepts the bundle this cycle.
imm  in  1  I bit.
mem_off  in  1  load/store immediate-offset mode.
shifter_operand  in  12  instruction bits [11:0].
val_rm  in  32  Rm value.
val_rs  in  8  Rs[7:0], the register shift amount.
c_in  in  1  current CPSR C flag.
out_valid  out  1  val2/c_out are valid.
out_ready  in  1  the consumer accepts the output.
val2  out  32  generated operand.
c_out  out  1  shifter carry-out.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - all stage valid bits clear; out_valid=0, val2=0, c_out=0.
  - in_ready=1 in the cycle after reset.
  - entries in flight when reset asserts are discarded.
- Handshake:
  - a transfer occurs on an edge where valid && ready.
  - The last stage advances when !out_valid || out_ready.
  - Each earlier stage advances when it is empty or the next stage advances.
  - in_ready = first stage empty || first stage advancing.
  - Throughput is 1 result per cycle with no bubbles under continuous out_ready.
  - While out_valid=1 && out_ready=0, val2 and c_out hold stable.
- flush=1 at an edge clears all valid bits. An input presented in the same cycle is dropped, even if in_ready=1. rst has priority over flush.
- Stage split for PIPE_DEPTH=2:
  - stage 1 decodes the mode, resolves the effective shift amount and registers operands.
  - stage 2 performs the barrel shift and carry and registers the outputs.
  - For PIPE_DEPTH=1 both steps happen in one stage.
- Mode priority: mem_off, then imm, then shifter_operand[4]=0 (immediate shift), then register shift.
- Mode mem_off: val2 = the 12-bit field extended per MEM_SEXT; c_out=c_in.
- Mode imm:
  - val2 = ROR({24'b0, so[7:0]}, 2*so[11:8]).
  - c_out = c_in if so[11:8]==0, else val2[31].
- Mode immediate shift: n = so[11:7], type = so[6:5].
  - LSL: n=0 gives Rm, c_in; otherwise Rm<<n, carry Rm[32-n].
  - LSR: n=0 means a shift by 32, giving 0, carry Rm[31]; otherwise Rm>>n, carry Rm[n-1].
  - ASR: n=0 means a shift by 32, giving 32{Rm[31]}, carry Rm[31]; otherwise arithmetic shift, carry Rm[n-1].
  - ROR: n=0 is RRX, giving {c_in, Rm[31:1]}, carry Rm[0]; otherwise ROR(Rm,n), carry Rm[n-1].
- Mode register shift (so[4]=1, so[7] ignored): s = val_rs[7:0]. If s=0 the result is Rm with carry c_in, for every type.
  - LSL: s<32 gives Rm<<s, carry Rm[32-s]; s=32 gives 0, carry Rm[0]; s>32 gives 0, carry 0.
  - LSR: s<32 gives Rm>>s, carry Rm[s-1]; s=32 gives 0, carry Rm[31]; s>32 gives 0, carry 0.
  - ASR: s>=32 gives 32{Rm[31]}, carry Rm[31].
  - ROR: s[4:0]=0 gives Rm, carry Rm[31]; otherwise ROR(Rm, s[4:0]), carry Rm[s[4:0]-1].
- All arithmetic is 32-bit; no X may propagate for any input combination. Shift amounts are computed at 6 bits internally.

Decomposition:
- Package val2_pkg holds:
  - localparams SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - a mode enum {MODE_MEM, MODE_IMM, MODE_ISH, MODE_RSH};
  - the constant DATA_W=32.
- One combinational sub-module, val2_barrel: inputs are Rm, effective amount (6 bits), type, c_in and an rrx flag; outputs are the result and carry. Stage 2 instantiates it.

Test Plan:
- Immediate rotate, gathered case: imm=1, so=0x4FF, out_ready=1 → val2=0xFF000000, c_out=1, out_valid exactly PIPE_DEPTH cycles after the accept. Same test with so=0x0FF, c_in=0 → val2=0x000000FF, c_out=0.
- Immediate-shift zero encodings: Rm=0x80000001.
  - LSR #0 (so=0x020) → val2=0, c_out=1.
  - ASR #0 (so=0x040) → 0xFFFFFFFF, c_out=1.
  - RRX (so=0x060), c_in=1, Rm=0x00000003 → 0x80000001, c_out=1.
- Register shift boundaries: Rm=0x00000001, so=0x010 (LSL by Rs).
  - Rs=32 → val2=0, c=1.
  - Rs=33 → val2=0, c=0.
  - Rs=0, c_in=1 → val2=1, c=1.
  - ROR with Rs=0x20 on Rm=0x80000000 → val2=0x80000000, c=1.
- Memory offset: mem_off=1, so=0xFFC → val2=0xFFFFFFFC (MEM_SEXT=1) or 0x00000FFC (MEM_SEXT=0).
- Back-pressure: stream 4 bundles with out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full, outputs hold stable, and all 4 results emerge in order with none lost or duplicated.
- Flush and reset mid-operation:
  - flush with 2 entries in flight plus a new input → out_valid=0 next cycle and nothing emerges.
  - rst asserted mid-stream → val2=0, c_out=0, out_valid=0 the next cycle.
